burst_addr_gen: RTL and testbench
=================================

// Module: burst_addr_gen
// PURPOSE
// - Parametrised burst address generator for the MRAM interface; next generation of the burst control path.
// - Accepts a start address, beat count and burst mode in parallel, then shifts each beat address out serially, MSB first, to the MRAM address port.
// - Supports SINGLE, INCR, WRAP and FIXED modes, a configurable stride, a per-beat acknowledge handshake and abort.
// - Sits between the host command decoder and the MRAM serial address / data sequencer.
// PARAMETERS
// - ADDR_W  16  address width in bits; also the number of serial shift cycles per beat.
// - LEN_W   5   burst length field width; beats = burst_len + 1, maximum 2^LEN_W.
// - STRIDE  1   address increment per beat; must be a power of 2 and at least 1.
// PORTS
// - clk            in   1       system clock, rising edge.
// - rst_n          in   1       asynchronous, active-low reset.
// - start          in   1       one-cycle request; sampled only in IDLE.
// - mode_sel       in   2       00 SINGLE, 01 INCR, 10 WRAP, 11 FIXED; latched on start.
// - start_addr     in   ADDR_W  first beat address; latched on start.
// - burst_len      in   LEN_W   beats-1; latched on start; ignored in SINGLE.
// - beat_ack       in   1       downstream has finished the current beat; sampled only in WAIT.
// - abort          in   1       cancels any burst in progress.
// - addr_sdo       out  1       serial address bit.
// - addr_sdo_valid out  1       high while addr_sdo carries a valid bit.
// - addr_sdo_last  out  1       high on the LSB, the final shift cycle of a beat.
// - addr_q         out  ADDR_W  current beat address, held stable from the SHIFT phase through WAIT.
// - beat_cnt       out  LEN_W   index of the current beat, counting from 0.
// - busy           out  1       high in every state except IDLE.
// - done           out  1       one-cycle pulse when the last beat completes.
// - aborted        out  1       one-cycle pulse on an abort.
// - err            out  1       one-cycle pulse when a start request is rejected.
// BEHAVIOUR
// - Reset: state returns to IDLE immediately (asynchronous); every output and every internal register is cleared to 0.
// - FSM states: IDLE, SHIFT, WAIT, DONE.
//   - IDLE -> SHIFT when start=1 and the request is valid. Cycle t = start; the MSB appears on addr_sdo at t+1.
//   - SHIFT lasts exactly ADDR_W cycles, MSB first; addr_sdo_valid=1 for all of them; addr_sdo_last=1 on the last.
//   - SHIFT -> WAIT after the LSB. WAIT holds until beat_ack=1.
//   - WAIT with beat_ack=1 and beat_cnt == len: go to DONE. done=1 for one cycle, then IDLE.
//   - WAIT with beat_ack=1 and beat_cnt < len: beat_cnt+1, addr_q takes the next address, go to SHIFT.
//   - Zero idle cycles between the ack and the next MSB.
// - Next-address rules:
//   - INCR: addr + STRIDE, modulo 2^ADDR_W; wraps from all-ones to 0 silently.
//   - WRAP: mask = (burst_len+1)*STRIDE - 1; next = (addr & ~mask) | ((addr + STRIDE) & mask).
//   - FIXED: addr is unchanged for every beat.
//   - SINGLE: exactly one beat; burst_len is treated as 0.
// - Rejection: in WRAP mode, if burst_len+1 is not a power of 2, err=1 for one cycle and the block stays in IDLE.
// - A start while busy=1 is ignored and does not raise err.
// - Abort, any non-IDLE state: next cycle IDLE, aborted=1 for one cycle, done is not asserted, addr_sdo_valid drops to 0.
// - Abort together with beat_ack on the last beat: abort wins, no done pulse.
// - Abort together with start in IDLE: start is ignored. abort alone in IDLE has no effect.
// - beat_ack outside WAIT is ignored. All outputs are registered.
// TESTING
// - INCR, start_addr=0x0010, burst_len=3, ack 2 cycles after each last -> addr_q 0x10,0x11,0x12,0x13; serial bits match addr_q; done after the 4th ack.
// - WRAP, start_addr=0x0006, burst_len=3 -> 0x6,0x7,0x4,0x5; WRAP with burst_len=2 -> err pulse, busy stays 0.
// - INCR, start_addr=0xFFFE, burst_len=3 -> 0xFFFE,0xFFFF,0x0000,0x0001; SINGLE with burst_len=7 -> one beat only.
// - FIXED, start_addr=0x1234, burst_len=1 -> two beats at 0x1234; beat_ack held high before WAIT -> no early advance.
// - Abort on the 5th SHIFT cycle of beat 1 -> aborted pulse, IDLE next cycle, no done; a new start is then accepted.
// - rst_n low mid-SHIFT -> all outputs 0 asynchronously; start asserted during busy -> ignored, sequence unaffected.

Source files
------------

// File: rtl/burst_addr_gen_if.sv
// burst_addr_gen_if: host/sequencer-facing signal bundle for the burst address generator.
interface burst_addr_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 5
);
  logic              start;
  logic [1:0]        mode_sel;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              beat_ack;
  logic              abort;
  logic              addr_sdo;
  logic              addr_sdo_valid;
  logic              addr_sdo_last;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;
  modport master (
    output start, mode_sel, start_addr, burst_len, beat_ack, abort,
    input  addr_sdo, addr_sdo_valid, addr_sdo_last, addr_q, beat_cnt, busy, done, aborted, err
  );
  modport slave (
    input  start, mode_sel, start_addr, burst_len, beat_ack, abort,
    output addr_sdo, addr_sdo_valid, addr_sdo_last, addr_q, beat_cnt, busy, done, aborted, err
  );
endinterface

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: latches a burst request and shifts each beat address out MSB first,
// advancing per beat in SINGLE/INCR/WRAP/FIXED mode under a beat_ack handshake with abort.
module burst_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 5,
  parameter int STRIDE = 1
) (
  input logic clk,
  input logic rst_n,
  burst_addr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;
  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_WRAP   = 2'd2;
  localparam logic [1:0] M_FIXED  = 2'd3;
  localparam int CNT_W = $clog2(ADDR_W + 1);
  state_t            state_q;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sh_q;
  logic [CNT_W-1:0]  bit_q;
  logic [LEN_W-1:0]  beat_q;
  logic              sdo_q;
  logic              vld_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              abt_q;
  logic              err_q;
  logic [LEN_W-1:0]  len_p1;
  logic              wrap_bad;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] addr_d;
  // WRAP needs a power-of-2 beat count; len & (len+1) is zero exactly then
  assign len_p1   = bus.burst_len + LEN_W'(1);
  assign wrap_bad = (bus.mode_sel == M_WRAP) && ((len_p1 & bus.burst_len) != '0);
  assign mask     = (ADDR_W'(len_q) + ADDR_W'(1)) * ADDR_W'(STRIDE) - ADDR_W'(1);
  assign inc      = addr_q + ADDR_W'(STRIDE);
  assign addr_d   = (mode_q == M_FIXED) ? addr_q :
                    (mode_q == M_WRAP)  ? ((addr_q & ~mask) | (inc & mask)) : inc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      beat_q  <= '0;
      sdo_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      abt_q  <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        state_q <= IDLE;
        sdo_q   <= 1'b0;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
        abt_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              if (wrap_bad) begin
                err_q <= 1'b1;
              end else begin
                state_q <= SHIFT;
                mode_q  <= bus.mode_sel;
                len_q   <= (bus.mode_sel == M_SINGLE) ? '0 : bus.burst_len;
                addr_q  <= bus.start_addr;
                sdo_q   <= bus.start_addr[ADDR_W-1];
                sh_q    <= bus.start_addr << 1;
                bit_q   <= '0;
                beat_q  <= '0;
                vld_q   <= 1'b1;
                last_q  <= (ADDR_W == 1);
                busy_q  <= 1'b1;
              end
            end
          end
          SHIFT: begin
            if (bit_q == CNT_W'(ADDR_W - 1)) begin
              state_q <= WAIT;
              sdo_q   <= 1'b0;
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              sdo_q  <= sh_q[ADDR_W-1];
              sh_q   <= sh_q << 1;
              bit_q  <= bit_q + CNT_W'(1);
              last_q <= (bit_q == CNT_W'(ADDR_W - 2));
            end
          end
          WAIT: begin
            if (bus.beat_ack) begin
              if (beat_q == len_q) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= SHIFT;
                beat_q  <= beat_q + LEN_W'(1);
                addr_q  <= addr_d;
                sdo_q   <= addr_d[ADDR_W-1];
                sh_q    <= addr_d << 1;
                bit_q   <= '0;
                vld_q   <= 1'b1;
                last_q  <= (ADDR_W == 1);
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.addr_sdo       = sdo_q;
  assign bus.addr_sdo_valid = vld_q;
  assign bus.addr_sdo_last  = last_q;
  assign bus.addr_q         = addr_q;
  assign bus.beat_cnt       = beat_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.aborted        = abt_q;
  assign bus.err            = err_q;
endmodule

// File: tb/tb_burst_addr_gen.sv
// tb_burst_addr_gen: directed bench for burst_addr_gen (16-bit addresses, stride 1).
module tb_burst_addr_gen;
  localparam int AW = 16;
  localparam int LW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [27:0] outs;
  always #5 clk = ~clk;
  burst_addr_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
  burst_addr_gen #(.ADDR_W(AW), .LEN_W(LW), .STRIDE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign outs = {bus.addr_sdo, bus.addr_sdo_valid, bus.addr_sdo_last, bus.addr_q, bus.beat_cnt,
                 bus.busy, bus.done, bus.aborted, bus.err};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_burst(input logic [1:0] m, input logic [15:0] a, input logic [4:0] l);
    bus.mode_sel = m;
    bus.start_addr = a;
    bus.burst_len = l;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  // Called on the negedge where the MSB is visible; returns on the first WAIT negedge.
  task automatic shift_beat(input string tag, input logic [15:0] ea, input logic [4:0] ec,
                            input bit early_ack, input bit poke);
    logic [15:0] bits, vld, lst;
    logic errs;
    bits = '0; vld = '0; lst = '0; errs = 1'b0;
    chk({tag, ".addr"}, 32'(bus.addr_q), 32'(ea));
    chk({tag, ".cnt"}, 32'(bus.beat_cnt), 32'(ec));
    if (early_ack) bus.beat_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bits[15-i] = bus.addr_sdo;
      vld[15-i] = bus.addr_sdo_valid;
      lst[15-i] = bus.addr_sdo_last;
      errs |= bus.err;
      if (poke && i == 4) begin
        bus.mode_sel = 2'd2;
        bus.burst_len = 5'd2;
        bus.start = 1'b1;
      end
      if (poke && i == 5) bus.start = 1'b0;
      @(negedge clk);
    end
    errs |= bus.err;
    chk({tag, ".bits"}, 32'(bits), 32'(ea));
    chk({tag, ".valid"}, 32'(vld), 32'hFFFF);
    chk({tag, ".last"}, 32'(lst), 32'h0001);
    chk({tag, ".noerr"}, 32'(errs), 32'h0);
    chk({tag, ".hold"}, 32'(bus.addr_q), 32'(ea));
    chk({tag, ".waitcnt"}, 32'(bus.beat_cnt), 32'(ec));
    chk({tag, ".waitvld"}, 32'(bus.addr_sdo_valid), 32'h0);
    chk({tag, ".waitbusy"}, 32'(bus.busy), 32'h1);
  endtask
  task automatic ack(input int gap);
    repeat (gap) @(negedge clk);
    bus.beat_ack = 1'b1;
    @(negedge clk);
    bus.beat_ack = 1'b0;
  endtask
  task automatic finish_burst(input string tag);
    chk({tag, ".done"}, 32'(bus.done), 32'h1);
    chk({tag, ".donebusy"}, 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk({tag, ".done0"}, 32'(bus.done), 32'h0);
    chk({tag, ".idle"}, 32'(bus.busy), 32'h0);
  endtask
  initial begin
    logic [15:0] wexp [4];
    logic [15:0] oexp [4];
    wexp = '{16'h0006, 16'h0007, 16'h0004, 16'h0005};
    oexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bus.start = 1'b0; bus.mode_sel = '0; bus.start_addr = '0; bus.burst_len = '0;
    bus.beat_ack = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", 32'(outs), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    start_burst(2'd1, 16'h0010, 5'd3);
    for (int b = 0; b < 4; b++) begin
      shift_beat("incr", 16'(16'h0010 + b), 5'(b), 1'b0, 1'b0);
      ack(1);
    end
    finish_burst("incr");
    start_burst(2'd2, 16'h0006, 5'd3);
    for (int b = 0; b < 4; b++) begin
      shift_beat("wrap", wexp[b], 5'(b), 1'b0, 1'b0);
      ack(1);
    end
    finish_burst("wrap");
    start_burst(2'd2, 16'h0006, 5'd2);
    chk("rej.err", 32'(bus.err), 32'h1);
    chk("rej.busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("rej.err0", 32'(bus.err), 32'h0);
    chk("rej.idle", 32'(outs[3:0]), 32'h0);
    start_burst(2'd1, 16'hFFFE, 5'd3);
    for (int b = 0; b < 4; b++) begin
      shift_beat("ovf", oexp[b], 5'(b), 1'b0, 1'b0);
      ack(1);
    end
    finish_burst("ovf");
    start_burst(2'd0, 16'h00A5, 5'd7);
    shift_beat("single", 16'h00A5, 5'd0, 1'b0, 1'b0);
    ack(1);
    finish_burst("single");
    start_burst(2'd3, 16'h1234, 5'd1);
    shift_beat("fix0", 16'h1234, 5'd0, 1'b1, 1'b1);
    ack(0);
    shift_beat("fix1", 16'h1234, 5'd1, 1'b1, 1'b0);
    ack(0);
    finish_burst("fixed");
    start_burst(2'd1, 16'h0100, 5'd3);
    shift_beat("abt0", 16'h0100, 5'd0, 1'b0, 1'b0);
    ack(1);
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort.pulse", 32'(bus.aborted), 32'h1);
    chk("abort.busy", 32'(bus.busy), 32'h0);
    chk("abort.valid", 32'(bus.addr_sdo_valid), 32'h0);
    chk("abort.nodone", 32'(bus.done), 32'h0);
    @(negedge clk);
    chk("abort.pulse0", 32'(bus.aborted), 32'h0);
    chk("abort.nodone2", 32'(bus.done), 32'h0);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort.idle", 32'(bus.aborted), 32'h0);
    start_burst(2'd1, 16'h0040, 5'd0);
    bus.abort = 1'b0;
    chk("abortstart.busy", 32'(bus.busy), 32'h0);
    chk("abortstart.abt", 32'(bus.aborted), 32'h0);
    start_burst(2'd1, 16'h0020, 5'd0);
    shift_beat("restart", 16'h0020, 5'd0, 1'b0, 1'b0);
    ack(1);
    finish_burst("restart");
    start_burst(2'd1, 16'h5555, 5'd1);
    repeat (3) @(negedge clk);
    chk("rst.pre", 32'(bus.addr_sdo_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("rst.async", 32'(outs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.after", 32'(outs), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
